// File: rtl/partial_product_accumulator_if.sv
// Handshake and data bundle between the multiplier lanes, the combining stage
// and the product consumer. The producer/consumer side uses the master modport,
// the accumulator uses the slave modport.
interface partial_product_accumulator_if #(
    parameter int PP_W  = 1280,
    parameter int OUT_W = 2048
);
    logic             in_valid;
    logic             in_ready;
    logic [PP_W-1:0]  pp0;
    logic [PP_W-1:0]  pp1;
    logic [PP_W-1:0]  pp2;
    logic [PP_W-1:0]  pp3;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] product;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid,
        output pp0,
        output pp1,
        output pp2,
        output pp3,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  product,
        input  ovf,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  pp0,
        input  pp1,
        input  pp2,
        input  pp3,
        input  out_ready,
        output in_ready,
        output out_valid,
        output product,
        output ovf,
        output busy
    );
endinterface

// File: rtl/partial_product_accumulator.sv
// Combining stage for the four-lane 1024x1024 multiplier.
// Lane i's partial product carries weight 2^(256*i). Instead of one wide
// four-operand add, the result is built one 256-bit chunk per cycle: chunk k
// sums the lane slices that overlap it plus the running 2-bit carry.
// Latency is 8 edges from the accepting edge to out_valid.
module partial_product_accumulator #(
    parameter int CHUNK_W = 256
) (
    input  logic                          clk,
    input  logic                          rstn,
    partial_product_accumulator_if.slave  bus
);
    localparam int LANES   = 4;
    localparam int PP_W    = 5 * CHUNK_W;
    localparam int OUT_W   = 8 * CHUNK_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                         state_reg;
    state_t                         state_next;
    logic [2:0]                     k_reg;
    logic [1:0]                     carry_reg;
    logic [OUT_W-1:0]               product_reg;
    logic                           ovf_reg;
    logic [PP_W-1:0]                pp_reg [LANES];

    logic [LANES-1:0][CHUNK_W-1:0]  lane_slice;
    logic [CHUNK_W+1:0]             chunk_sum;
    logic                           accept;
    logic                           in_ready_c;
    logic                           out_valid_c;
    logic                           busy_c;

    // State register; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next  = state_reg;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b1;
        accept      = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready_c = 1'b1;
                busy_c     = 1'b0;
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (k_reg == 3'd7) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Consumer handshake returns to IDLE on the following edge;
                // a new operand set is never taken in the same cycle.
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Per-lane slice for the current chunk: lane gi contributes its chunk
    // (k - gi) when that index lies in 0..4, otherwise zero. The subtraction
    // is done at 4 bits so a negative offset wraps to a value above 4.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [3:0]         off;
        logic [CHUNK_W-1:0] slice;

        // Select this lane's overlapping slice for chunk k_reg.
        always_comb begin
            off   = {1'b0, k_reg} - 4'(gi);
            slice = '0;
            if (off <= 4'd4) begin
                slice = pp_reg[gi][off*CHUNK_W +: CHUNK_W];
            end
        end

        assign lane_slice[gi] = slice;
    end

    // Narrow chunk adder: four slices plus carry-in, two extra bits of headroom.
    always_comb begin
        chunk_sum = {2'b00, lane_slice[0]}
                  + {2'b00, lane_slice[1]}
                  + {2'b00, lane_slice[2]}
                  + {2'b00, lane_slice[3]}
                  + {{CHUNK_W{1'b0}}, carry_reg};
    end

    // Operand capture, chunk accumulation and result hold.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            k_reg       <= 3'd0;
            carry_reg   <= 2'd0;
            product_reg <= '0;
            ovf_reg     <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                pp_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        pp_reg[0]   <= bus.pp0;
                        pp_reg[1]   <= bus.pp1;
                        pp_reg[2]   <= bus.pp2;
                        pp_reg[3]   <= bus.pp3;
                        product_reg <= '0;
                        k_reg       <= 3'd0;
                        carry_reg   <= 2'd0;
                        ovf_reg     <= 1'b0;
                    end
                end
                ACCUM: begin
                    product_reg[k_reg*CHUNK_W +: CHUNK_W] <= chunk_sum[CHUNK_W-1:0];
                    carry_reg <= chunk_sum[CHUNK_W+1:CHUNK_W];
                    k_reg     <= k_reg + 3'd1;
                    if (k_reg == 3'd7) begin
                        // Carry out of the top chunk only appears for inputs
                        // that are not a legal split 1024x1024 product.
                        ovf_reg <= (chunk_sum[CHUNK_W+1:CHUNK_W] != 2'd0);
                    end
                end
                default: begin
                    // DONE holds product and ovf; product also persists
                    // through IDLE until the next accept clears it.
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = busy_c;
    assign bus.product   = product_reg;
    assign bus.ovf       = ovf_reg;

endmodule
